uart_pkt_tx: RTL and testbench

UART_PKT_TX -- requirements
Module: uart_pkt_tx

---
 rtl/uart_pkt_tx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_pkt_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx: buffers payload bytes in a FIFO and, on send, frames them for a
// byte-oriented UART transmitter as SOF, LEN, payload..., CHK where
// CHK = (LEN + sum of payload) mod 256.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   wr_en      push wr_data into the payload FIFO (dropped when full)
//   wr_data    payload byte
//   send       request one packet of all bytes buffered at that moment
//   tx_done    pulse from the UART: current byte finished
//   tx_start   pulse to the UART: start sending data_in
//   data_in    byte presented to the UART, held until tx_done
//   count      bytes currently buffered
//   full       count == DEPTH
//   busy       packet in progress
//   pkt_done   pulse when the CHK byte has been sent
//   err_empty  pulse when send arrived with an empty buffer
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no packet; accepts send
// START | tx_start high for this cycle; payload pop happens here
// WAIT  | byte on the wire, waiting for tx_done
//
// field | byte being sent
// ------+-----------------------------------------------------------
// SOF   | start-of-frame constant
// LEN   | latched packet length
// PAY   | payload bytes, rem_q counts those still to send
// CHK   | running checksum
module uart_pkt_tx #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] SOF   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   send,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [7:0]             data_in,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   busy,
    output logic                   pkt_done,
    output logic                   err_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
    typedef enum logic [1:0] {F_SOF, F_LEN, F_PAY, F_CHK} field_t;

    logic [7:0]    mem [DEPTH];

    state_t        state_q, state_d;
    field_t        field_q, field_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   rem_q, rem_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    data_in_q, data_in_d;
    logic          tx_start_q, tx_start_d;
    logic          busy_q, busy_d;
    logic          pkt_done_q, pkt_done_d;
    logic          err_empty_q, err_empty_d;
    logic          full_q, full_d;

    logic          push, pop;
    logic [7:0]    head;

    assign tx_start  = tx_start_q;
    assign data_in   = data_in_q;
    assign count     = count_q;
    assign full      = full_q;
    assign busy      = busy_q;
    assign pkt_done  = pkt_done_q;
    assign err_empty = err_empty_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        push = wr_en && !full_q;
        pop  = (state_q == S_START) && (field_q == F_PAY);
        head = mem[rd_ptr_q];

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        state_d     = state_q;
        field_d     = field_q;
        len_d       = len_q;
        rem_d       = rem_q;
        chk_d       = chk_q;
        data_in_d   = data_in_q;
        tx_start_d  = 1'b0;
        pkt_done_d  = 1'b0;
        err_empty_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The pkt_done cycle still counts as the tail of the previous
                // packet, so a send landing there is ignored.
                if (send && !pkt_done_q) begin
                    if (count_q != '0) begin
                        len_d      = count_q;
                        rem_d      = count_q;
                        chk_d      = 8'h00;
                        field_d    = F_SOF;
                        data_in_d  = SOF;
                        tx_start_d = 1'b1;
                        state_d    = S_START;
                    end else begin
                        err_empty_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    case (field_q)
                        F_SOF: begin
                            field_d    = F_LEN;
                            data_in_d  = 8'(len_q);
                            chk_d      = chk_q + 8'(len_q);
                            tx_start_d = 1'b1;
                            state_d    = S_START;
                        end
                        F_LEN, F_PAY: begin
                            // LEN >= 1, so LEN always leads to at least one payload byte.
                            if (field_q == F_PAY && rem_q == '0) begin
                                field_d   = F_CHK;
                                data_in_d = chk_q;
                            end else begin
                                // head is the byte popped in the coming START cycle
                                field_d   = F_PAY;
                                data_in_d = head;
                                chk_d     = chk_q + head;
                                rem_d     = rem_q - CNT_ONE;
                            end
                            tx_start_d = 1'b1;
                            state_d    = S_START;
                        end
                        F_CHK: begin
                            pkt_done_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        full_d = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            field_q     <= F_SOF;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            chk_q       <= 8'h00;
            data_in_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_empty_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            chk_q       <= chk_d;
            data_in_q   <= data_in_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            pkt_done_q  <= pkt_done_d;
            err_empty_q <= err_empty_d;
            full_q      <= full_d;
        end
    end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Bench for uart_pkt_tx: directed scenarios, a frame-level reference model
// checked every cycle, and literal frame expectations per scenario.
module tb_uart_pkt_tx;

    localparam int DEPTH = 16;

    logic       clk, rst, wr_en, send, auto_done, man_done;
    logic [7:0] wr_data;
    logic       tx_start, full, busy, pkt_done, err_empty;
    logic [7:0] data_in;
    logic [4:0] count;

    uart_pkt_tx #(.DEPTH(DEPTH), .SOF(8'hA5)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .send(send),
        .tx_done(auto_done | man_done), .tx_start(tx_start), .data_in(data_in),
        .count(count), .full(full), .busy(busy), .pkt_done(pkt_done),
        .err_empty(err_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] fifo_m [$];
    logic [7:0] frame [$];
    logic [7:0] obs [$];
    logic [7:0] exp_q [$];
    int  pos;
    bit  active, waiting, exp_start, exp_pkt, exp_err;
    int  starts_obs = 0;

    always @(negedge clk) begin
        int  sz, len, sum;
        bit  push_ok, pop_now, n_start, n_pkt, n_err, tx_done_now;
        tx_done_now = auto_done | man_done;
        if (!rst) begin
            chk("rst_tx_start", tx_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_pkt_done", pkt_done, 0);
            chk("rst_err_empty", err_empty, 0);
            chk("rst_full", full, 0);
            chk("rst_count", count, 0);
            chk("rst_data_in", data_in, 0);
            fifo_m.delete();
            frame.delete();
            pos = 0; active = 0; waiting = 0;
            exp_start = 0; exp_pkt = 0; exp_err = 0;
        end else begin
            sz = fifo_m.size();
            chk("tx_start", tx_start, exp_start);
            chk("busy", busy, active || exp_start);
            chk("pkt_done", pkt_done, exp_pkt);
            chk("err_empty", err_empty, exp_err);
            chk("count", count, sz);
            chk("full", full, sz == DEPTH);
            if ((exp_start || waiting) && pos < frame.size())
                chk("data_in", data_in, frame[pos]);

            if (tx_start) begin
                starts_obs++;
                obs.push_back(data_in);
            end

            n_start = 0; n_pkt = 0; n_err = 0; pop_now = 0;
            if (exp_start) begin
                pop_now = (pos >= 2) && (pos < frame.size() - 1);
            end
            if (waiting && tx_done_now) begin
                waiting = 0;
                pos++;
                if (pos == frame.size()) begin
                    n_pkt  = 1;
                    active = 0;
                end else begin
                    n_start = 1;
                end
            end
            if (exp_start) waiting = 1;
            if (send && !active && !exp_pkt) begin
                if (sz > 0) begin
                    len = sz;
                    sum = len;
                    frame.delete();
                    frame.push_back(8'hA5);
                    frame.push_back(len[7:0]);
                    for (int i = 0; i < len; i++) begin
                        frame.push_back(fifo_m[i]);
                        sum += fifo_m[i];
                    end
                    frame.push_back(sum[7:0]);
                    pos = 0;
                    active = 1;
                    n_start = 1;
                end else begin
                    n_err = 1;
                end
            end
            push_ok = wr_en && (sz < DEPTH);
            if (push_ok) fifo_m.push_back(wr_data);
            if (pop_now) void'(fifo_m.pop_front());
            exp_start = n_start;
            exp_pkt   = n_pkt;
            exp_err   = n_err;
        end
    end

    // ---------------- UART responder ----------------
    bit auto_en = 1;
    int lat = 2;
    int dones = 0;

    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_en && rst && tx_start) begin
                repeat (lat) @(posedge clk);
                #1 auto_done = 1'b1;
                @(posedge clk);
                #1 auto_done = 1'b0;
                dones++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_send();
        send = 1'b1;
        step();
        send = 1'b0;
    endtask

    task automatic wait_pkt(input string nm);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (pkt_done) seen = 1;
        end
        chk({nm, "_pkt_done_seen"}, seen, 1);
    endtask

    task automatic check_frame(input string nm);
        chk({nm, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk({nm, "_byte"}, obs[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit reached;
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; send = 1'b0; man_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // basic three-byte packet
        obs.delete();
        push(8'h01); push(8'h02); push(8'h03);
        chk("s1_count_pre", count, 3);
        do_send();
        wait_pkt("s1");
        step();
        exp_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        check_frame("s1_frame");
        chk("s1_count_post", count, 0);

        // send with empty buffer
        do_send();
        chk("s2_err_empty", err_empty, 1);
        chk("s2_busy", busy, 0);
        chk("s2_tx_start", tx_start, 0);
        step();
        chk("s2_err_empty_off", err_empty, 0);

        // overfill: 17th byte dropped
        obs.delete();
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("s3_count", count, 16);
        chk("s3_full", full, 1);
        do_send();
        wait_pkt("s3");
        step();
        exp_q = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h88);
        check_frame("s3_frame");
        chk("s3_count_post", count, 0);
        chk("s3_full_post", full, 0);

        // push during packet stays for next packet
        lat = 4;
        obs.delete();
        push(8'hFF); push(8'hFF);
        do_send();
        step();
        push(8'h07);
        wait_pkt("s4a");
        step();
        exp_q = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00};
        check_frame("s4a_frame");
        chk("s4_count_left", count, 1);
        obs.delete();
        do_send();
        wait_pkt("s4b");
        step();
        exp_q = '{8'hA5, 8'h01, 8'h07, 8'h08};
        check_frame("s4b_frame");
        lat = 2;

        // reset after second tx_done
        push(8'h11); push(8'h22);
        base = dones;
        do_send();
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            if (dones - base >= 2) reached = 1;
        end
        chk("s5_two_dones", reached, 1);
        rst = 1'b0;
        #1;
        chk("s5_busy_rst", busy, 0);
        chk("s5_count_rst", count, 0);
        chk("s5_pkt_done_rst", pkt_done, 0);
        step(); step(); step();
        rst = 1'b1;
        step();
        obs.delete();
        push(8'h5A);
        do_send();
        wait_pkt("s5");
        step();
        exp_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        check_frame("s5_frame");

        // stray tx_done / send are ignored
        auto_en = 0;
        obs.delete();
        man_done = 1'b1; step(); man_done = 1'b0;
        step();
        chk("s6_idle_done_busy", busy, 0);
        push(8'h44);
        base = starts_obs;
        do_send();
        man_done = 1'b1; step(); man_done = 1'b0;
        send = 1'b1; step(); send = 1'b0;
        step();
        chk("s6_single_start", starts_obs - base, 1);
        chk("s6_busy", busy, 1);
        for (int b = 0; b < 4; b++) begin
            man_done = 1'b1; step(); man_done = 1'b0;
            step(); step();
        end
        exp_q = '{8'hA5, 8'h01, 8'h44, 8'h45};
        check_frame("s6_frame");
        chk("s6_idle", busy, 0);
        auto_en = 1;

        // back-to-back: send in pkt_done cycle ignored, next cycle accepted
        obs.delete();
        push(8'h61);
        do_send();
        step();
        push(8'h62);
        wait_pkt("s7a");
        send = 1'b1;
        step();
        step();
        send = 1'b0;
        wait_pkt("s7b");
        step();
        exp_q = '{8'hA5, 8'h01, 8'h61, 8'h62, 8'hA5, 8'h01, 8'h62, 8'h63};
        check_frame("s7_frame");
        chk("s7_count", count, 0);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
